tx_framer: RTL and testbench
============================

Name: tx_framer

Overview:
- Downstream consumer of the TX preamble generator.
- Builds one serial TX frame per start pulse, one bit per clock, in this order:
  - preamble (gated from the preamble generator)
  - 24-bit SIGNAL header: RATE, reserved, LENGTH, parity, tail
  - payload bytes, LSB first
  - 6 tail zeros
- Feeds the downstream scrambler/encoder; pulls payload from a byte source over a ready/valid handshake.

Parameters:
- PRE_LEN, 16, number of preamble bits taken from the preamble generator.
- LEN_W, 12, width of the LENGTH field in bytes; fixed at 12 for the header layout.
- TAIL_LEN, 6, number of zero tail bits after the payload.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle frame request; sampled only in IDLE.
- rate  input  4  RATE field; captured at start.
- length  input  12  payload length in bytes; captured at start.
- preamble_bit  input  1  serial bit from the preamble generator.
- preamble_en  output  1  enable to the preamble generator.
- data_in  input  8  payload byte.
- data_valid  input  1  data_in valid.
- data_ready  output  1  framer takes data_in this cycle if data_valid=1.
- bit_out  output  1  serial frame bit.
- bit_valid  output  1  bit_out valid.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the last tail bit.
- err_underrun  output  1  one-cycle pulse on payload underrun.

Behaviour:
- Reset:
  - While reset=0, state=IDLE and every output=0.
  - Captured rate/length, counters and shift register are cleared.
  - Reset mid-frame aborts immediately; no done pulse.
- States: IDLE, PRE, HDR, PAY, TAIL.
- IDLE:
  - On start=1, capture rate/length, build the header word, go to PRE.
  - busy rises the next cycle.
- PRE:
  - preamble_en=1 for exactly PRE_LEN cycles.
  - Each cycle, preamble_bit is registered into bit_out with bit_valid=1.
  - Then go to HDR.
- HDR: 24 cycles, emitted bit0 first:
  - [3:0]=rate
  - [4]=0
  - [16:5]=length (LSB first)
  - [17]=even parity over bits 0..16
  - [23:18]=0
  - Next state is PAY if length≠0, else TAIL.
- PAY:
  - 8 cycles per byte.
  - data_ready=1 only in the first cycle of each byte slot.
  - If data_valid=1 in that cycle, the byte is loaded and bit0 is emitted in the same slot.
  - If data_valid=0: underrun.
    - err_underrun pulses next cycle; bit_valid=0 from that cycle.
    - busy clears and state goes to IDLE; no tail, no done.
  - After byte count == length, go to TAIL.
- TAIL: TAIL_LEN cycles with bit_out=0 and bit_valid=1; then IDLE.
- done pulses in the cycle after the last tail bit_valid; busy falls in the same cycle.
- Output timing and continuity:
  - bit_out, bit_valid, done and err_underrun are registered, one cycle behind the state cycle that produces them.
  - preamble_en and data_ready are combinational from state/counters.
  - The bit stream is gapless from the first preamble bit to the last tail bit.
  - Total bit_valid cycles = PRE_LEN + 24 + 8·length + TAIL_LEN.
- start while busy is ignored, including in the done cycle.
- A new start is accepted from the first cycle after busy=0.
- length=4095 is legal; the byte counter is 12 bits with no wrap.

Decomposition:
- Shared package tx_pkg:
  - state encoding enum
  - HDR_LEN=24
  - header field offsets (RATE_LSB=0, LEN_LSB=5, PAR_BIT=17)
  - TAIL_LEN default
- Sub-module tx_hdr_build (combinational):
  - inputs: rate, length
  - output: 24-bit header word with parity
  - reused by the RX-side header checker.
- The FSM, counters and the 8-bit payload shift register stay in tx_framer.

Test Plan:
- Preamble generator driving 16'hAAAA pattern; start with rate=4'b1101, length=1, byte 8'hA5:
  - bits 1..16 = 0,1 alternating as supplied
  - header bits 0..3 = 1,0,1,1; bit4=0
  - length bits = 1 then eleven 0s; parity=0; six tail zeros in the header
  - payload = 1,0,1,0,0,1,0,1; six tail zeros
  - total 54 valid cycles; done once.
- length=0, rate=4'hB: 46 bit_valid cycles; data_ready never asserted.
- length=3, data_valid dropped on the 2nd byte request: err_underrun pulses once; bit_valid stops after byte 1's 8 bits; no done; busy=0.
- reset=0 asserted during HDR: all outputs 0 the same cycle; after release, start works normally.
- start pulsed during PAY and on the done cycle: both ignored; start one cycle after done launches a new frame.
- Parity sweep: rate=4'h1, length=12'h001 → parity bit 0; rate=4'h1, length=12'h003 → parity bit 1.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared definitions for the TX framing path: state encoding and SIGNAL header layout.
package tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_PAY  = 3'd3,
        ST_TAIL = 3'd4
    } tx_state_t;

    // SIGNAL header geometry
    localparam int unsigned HDR_LEN  = 24;
    localparam int unsigned RATE_LSB = 0;
    localparam int unsigned LEN_LSB  = 5;
    localparam int unsigned PAR_BIT  = 17;

    // Default number of zero tail bits closing a frame
    localparam int unsigned TAIL_LEN_DEF = 6;

endpackage

// File: rtl/tx_hdr_build.sv
// Combinational SIGNAL header builder: RATE, reserved, LENGTH, even parity, zero tail.
module tx_hdr_build
    import tx_pkg::*;
(
    input  logic [3:0]         rate,
    input  logic [11:0]        length,
    output logic [HDR_LEN-1:0] hdr
);

    logic [PAR_BIT-1:0] fields;

    // Pack the parity-covered fields; the reserved bit stays zero
    always_comb begin
        fields                 = '0;
        fields[RATE_LSB +: 4]  = rate;
        fields[LEN_LSB +: 12]  = length;
    end

    assign hdr = {{(HDR_LEN - PAR_BIT - 1){1'b0}}, ^fields, fields};

endmodule

// File: rtl/tx_framer.sv
// Serial TX frame builder: gated preamble, SIGNAL header, LSB-first payload, zero tail.
module tx_framer
    import tx_pkg::*;
#(
    parameter int unsigned PRE_LEN  = 16,
    parameter int unsigned LEN_W    = 12,
    parameter int unsigned TAIL_LEN = TAIL_LEN_DEF
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       rate,
    input  logic [LEN_W-1:0] length,
    input  logic             preamble_bit,
    output logic             preamble_en,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic             err_underrun
);

    localparam int unsigned MAX_A  = (PRE_LEN > HDR_LEN) ? PRE_LEN : HDR_LEN;
    localparam int unsigned MAX_PH = (MAX_A > TAIL_LEN) ? MAX_A : TAIL_LEN;
    localparam int unsigned CNT_W  = $clog2(MAX_PH + 1);

    tx_state_t          state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [LEN_W-1:0]   byte_cnt;
    logic [LEN_W-1:0]   byte_cnt_nxt;
    logic [LEN_W-1:0]   len_r;
    logic [HDR_LEN-1:0] hdr_word;
    logic [HDR_LEN-1:0] hdr_r;
    logic [6:0]         pay_sh;
    logic               fin;

    logic pre_last, hdr_last, byte_last, tail_last, slot_first, start_ok;

    tx_hdr_build u_hdr (
        .rate   (rate),
        .length (length),
        .hdr    (hdr_word)
    );

    assign pre_last     = (bit_cnt == CNT_W'(PRE_LEN - 1));
    assign hdr_last     = (bit_cnt == CNT_W'(HDR_LEN - 1));
    assign byte_last    = (bit_cnt == CNT_W'(7));
    assign tail_last    = (bit_cnt == CNT_W'(TAIL_LEN - 1));
    assign slot_first   = (bit_cnt == '0);
    assign byte_cnt_nxt = byte_cnt + LEN_W'(1);

    // busy and done are both checked so a start in the done cycle is dropped
    assign start_ok = start && (state == ST_IDLE) && !busy && !done;

    assign preamble_en = (state == ST_PRE);
    assign data_ready  = (state == ST_PAY) && slot_first;

    // Frame FSM with registered serial output; done trails the last tail bit by one cycle via fin
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            len_r        <= '0;
            hdr_r        <= '0;
            pay_sh       <= '0;
            fin          <= 1'b0;
            bit_out      <= 1'b0;
            bit_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            bit_out      <= 1'b0;
            bit_valid    <= 1'b0;
            err_underrun <= 1'b0;
            fin          <= 1'b0;
            done         <= fin;
            if (fin) begin
                busy <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        len_r    <= length;
                        hdr_r    <= hdr_word;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_PRE;
                    end
                end

                ST_PRE: begin
                    bit_out   <= preamble_bit;
                    bit_valid <= 1'b1;
                    if (pre_last) begin
                        bit_cnt <= '0;
                        state   <= ST_HDR;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                ST_HDR: begin
                    bit_out   <= hdr_r[0];
                    bit_valid <= 1'b1;
                    hdr_r     <= hdr_r >> 1;
                    if (hdr_last) begin
                        bit_cnt <= '0;
                        state   <= (len_r != '0) ? ST_PAY : ST_TAIL;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                ST_PAY: begin
                    if (slot_first) begin
                        if (data_valid) begin
                            bit_out   <= data_in[0];
                            bit_valid <= 1'b1;
                            pay_sh    <= data_in[7:1];
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                        end else begin
                            err_underrun <= 1'b1;
                            busy         <= 1'b0;
                            bit_cnt      <= '0;
                            state        <= ST_IDLE;
                        end
                    end else begin
                        bit_out   <= pay_sh[0];
                        bit_valid <= 1'b1;
                        pay_sh    <= pay_sh >> 1;
                        if (byte_last) begin
                            bit_cnt  <= '0;
                            byte_cnt <= byte_cnt_nxt;
                            if (byte_cnt_nxt == len_r) begin
                                state <= ST_TAIL;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_TAIL: begin
                    bit_valid <= 1'b1;
                    if (tail_last) begin
                        bit_cnt <= '0;
                        fin     <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_framer.sv
// Self-checking bench for tx_framer: frame bits compared against a list built from the frame layout rules.
`timescale 1ns/1ps
module tb_tx_framer;

    localparam int PRE_LEN   = 16;
    localparam int HDR_BITS  = 24;
    localparam int TAIL_BITS = 6;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic [3:0]  rate   = '0;
    logic [11:0] length = '0;
    logic        preamble_bit, preamble_en;
    logic [7:0]  data_in;
    logic        data_valid, data_ready;
    logic        bit_out, bit_valid, busy, done, err_underrun;

    int checks = 0;
    int errors = 0;

    tx_framer #(.PRE_LEN(16), .LEN_W(12), .TAIL_LEN(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rate         (rate),
        .length       (length),
        .preamble_bit (preamble_bit),
        .preamble_en  (preamble_en),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .busy         (busy),
        .done         (done),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    // Preamble generator and byte source models
    logic [15:0] pre_pat = 16'hAAAA;
    logic [7:0]  pay_mem [0:4095];
    int pay_n = 0, drop_at = -1;
    int pre_idx = 0, pre_base = 0, byte_idx = 0, byte_base = 0;
    int pre_off, byte_off;
    int cyc = 0;

    assign pre_off      = pre_idx - pre_base;
    assign byte_off     = byte_idx - byte_base;
    assign preamble_bit = pre_pat[pre_off[3:0]];
    assign data_in      = pay_mem[byte_off[11:0]];
    assign data_valid   = (byte_off < pay_n) && (byte_off != drop_at);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preamble_en) pre_idx <= pre_idx + 1;
        if (data_ready && data_valid) byte_idx <= byte_idx + 1;
    end

    // Output monitor
    logic got[$];
    int   got_cyc[$];
    int   n_done = 0, n_err = 0, n_ready = 0;

    always @(negedge clk) begin
        if (bit_valid) begin
            got.push_back(bit_out);
            got_cyc.push_back(cyc);
        end
        if (done)         n_done  <= n_done + 1;
        if (err_underrun) n_err   <= n_err + 1;
        if (data_ready)   n_ready <= n_ready + 1;
    end

    logic exp_q[$];
    int got_base, done_base, err_base, ready_base;
    int n_got, n_bad, d_done, d_err, d_ready, first_cyc;
    bit gap_ok;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Reference frame: preamble, header from field rules, payload LSB first, zero tail
    task automatic build_exp(input logic [3:0] r, input logic [11:0] len, input int drop);
        int nb;
        int par;
        bit aborted;
        exp_q.delete();
        for (int i = 0; i < PRE_LEN; i++) exp_q.push_back(pre_pat[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(r[i]);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 12; i++) exp_q.push_back(len[i]);
        par = ($countones(r) + $countones(len)) % 2;
        exp_q.push_back(par[0]);
        repeat (6) exp_q.push_back(1'b0);
        aborted = (drop >= 0) && (drop < int'(len));
        nb = aborted ? drop : int'(len);
        for (int b = 0; b < nb; b++)
            for (int i = 0; i < 8; i++) exp_q.push_back(pay_mem[b][i]);
        if (!aborted) repeat (TAIL_BITS) exp_q.push_back(1'b0);
    endtask

    task automatic prep(input logic [3:0] r, input logic [11:0] len, input int drop);
        pre_base   = pre_idx;
        byte_base  = byte_idx;
        pay_n      = int'(len);
        drop_at    = drop;
        got_base   = got.size();
        done_base  = n_done;
        err_base   = n_err;
        ready_base = n_ready;
        build_exp(r, len, drop);
    endtask

    task automatic launch(input logic [3:0] r, input logic [11:0] len);
        rate   = r;
        length = len;
        start  = 1'b1;
        step();
        start  = 1'b0;
        rate   = 4'($urandom);
        length = 12'($urandom);
    endtask

    task automatic collect();
        n_got = got.size() - got_base;
        n_bad = 0;
        for (int i = 0; i < n_got; i++)
            if (i >= exp_q.size() || got[got_base + i] !== exp_q[i]) n_bad++;
        gap_ok    = (n_got == 0) || (got_cyc[got.size() - 1] - got_cyc[got_base] + 1 == n_got);
        first_cyc = (n_got > 0) ? got_cyc[got_base] : -1;
        d_done    = n_done - done_base;
        d_err     = n_err - err_base;
        d_ready   = n_ready - ready_base;
    endtask

    task automatic wait_end(input int budget);
        int k;
        k = 0;
        while (!(done || err_underrun) && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL frame_end_timeout waited %0d cycles without done or err_underrun", k);
        end
        step(3);
        collect();
    endtask

    task automatic run(input logic [3:0] r, input logic [11:0] len, input int drop);
        prep(r, len, drop);
        launch(r, len);
        wait_end(PRE_LEN + HDR_BITS + 8 * int'(len) + TAIL_BITS + 20);
    endtask

    task automatic test_reset();
        step(2);
        checks++;
        if ({bit_out, bit_valid, busy, done, err_underrun, preamble_en, data_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0000000",
                     {bit_out, bit_valid, busy, done, err_underrun, preamble_en, data_ready});
        end
        reset = 1'b1;
        step(2);
        checks++;
        if ({bit_valid, busy, preamble_en, data_ready} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset got %b exp 0000", {bit_valid, busy, preamble_en, data_ready});
        end
    endtask

    task automatic test_basic();
        logic [3:0] hlo;
        logic [7:0] pb;
        pre_pat    = 16'hAAAA;
        pay_mem[0] = 8'hA5;
        run(4'b1101, 12'd1, -1);
        for (int i = 0; i < 4; i++) hlo[i] = got[got_base + PRE_LEN + i];
        for (int i = 0; i < 8; i++) pb[i] = got[got_base + PRE_LEN + HDR_BITS + i];
        checks++; if (n_got !== 54) begin errors++; $display("FAIL basic_count got %0d exp 54", n_got); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL basic_bits bad %0d exp 0", n_bad); end
        checks++; if (hlo !== 4'b1101) begin errors++; $display("FAIL basic_rate_bits got %b exp 1101", hlo); end
        checks++; if (got[got_base + PRE_LEN + 17] !== 1'b0) begin errors++; $display("FAIL basic_parity got %b exp 0", got[got_base + PRE_LEN + 17]); end
        checks++; if (pb !== 8'hA5) begin errors++; $display("FAIL basic_payload got %h exp a5", pb); end
        checks++; if (d_done !== 1 || d_err !== 0) begin errors++; $display("FAIL basic_done got done %0d err %0d exp 1 0", d_done, d_err); end
        checks++; if (!gap_ok || busy !== 1'b0) begin errors++; $display("FAIL basic_gap_busy got gap_ok %0d busy %b exp 1 0", gap_ok, busy); end
    endtask

    task automatic test_len0();
        run(4'hB, 12'd0, -1);
        checks++; if (n_got !== 46) begin errors++; $display("FAIL len0_count got %0d exp 46", n_got); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL len0_bits bad %0d exp 0", n_bad); end
        checks++; if (d_ready !== 0) begin errors++; $display("FAIL len0_ready got %0d exp 0", d_ready); end
        checks++; if (d_done !== 1) begin errors++; $display("FAIL len0_done got %0d exp 1", d_done); end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 3; i++) pay_mem[i] = 8'($urandom);
        run(4'h7, 12'd3, 1);
        checks++; if (n_got !== PRE_LEN + HDR_BITS + 8) begin errors++; $display("FAIL underrun_count got %0d exp %0d", n_got, PRE_LEN + HDR_BITS + 8); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL underrun_bits bad %0d exp 0", n_bad); end
        checks++; if (d_err !== 1 || d_done !== 0) begin errors++; $display("FAIL underrun_flags got err %0d done %0d exp 1 0", d_err, d_done); end
        checks++; if (busy !== 1'b0 || bit_valid !== 1'b0) begin errors++; $display("FAIL underrun_idle got busy %b valid %b exp 0 0", busy, bit_valid); end
    endtask

    task automatic test_reset_mid();
        pay_mem[0] = 8'($urandom);
        pay_mem[1] = 8'($urandom);
        prep(4'h5, 12'd2, -1);
        launch(4'h5, 12'd2);
        step(20);
        reset = 1'b0;
        #1;
        checks++;
        if ({bit_out, bit_valid, busy, done, err_underrun, preamble_en, data_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %b exp 0000000",
                     {bit_out, bit_valid, busy, done, err_underrun, preamble_en, data_ready});
        end
        step(2);
        reset = 1'b1;
        step(2);
        collect();
        checks++; if (d_done !== 0) begin errors++; $display("FAIL reset_mid_no_done got %0d exp 0", d_done); end
        pay_mem[0] = 8'($urandom);
        pay_mem[1] = 8'($urandom);
        run(4'hE, 12'd2, -1);
        checks++; if (n_got !== 62 || n_bad !== 0) begin errors++; $display("FAIL reset_mid_restart got count %0d bad %0d exp 62 0", n_got, n_bad); end
        checks++; if (d_done !== 1) begin errors++; $display("FAIL reset_mid_restart_done got %0d exp 1", d_done); end
    endtask

    task automatic test_start_ignored();
        int k, dcyc;
        pay_mem[0] = 8'($urandom);
        pay_mem[1] = 8'($urandom);
        prep(4'h6, 12'd2, -1);
        launch(4'h6, 12'd2);
        k = 0;
        while (!data_ready && k < 100) begin step(); k++; end
        rate = 4'h9; length = 12'd7; start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!done && k < 200) begin step(); k++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_first_done got %b exp 1", done); end
        dcyc = cyc;
        collect();
        checks++; if (n_got !== 62 || n_bad !== 0) begin errors++; $display("FAIL ign_first_frame got count %0d bad %0d exp 62 0", n_got, n_bad); end
        // start held across the done cycle and the one after it
        start = 1'b1; rate = 4'h3; length = 12'd1;
        pay_mem[0] = 8'h3C;
        prep(4'h3, 12'd1, -1);
        step(2);
        start = 1'b0;
        wait_end(PRE_LEN + HDR_BITS + 8 + TAIL_BITS + 20);
        checks++; if (n_got !== 54 || n_bad !== 0) begin errors++; $display("FAIL ign_second_frame got count %0d bad %0d exp 54 0", n_got, n_bad); end
        checks++; if (first_cyc !== dcyc + 3) begin errors++; $display("FAIL ign_restart_timing got %0d exp %0d", first_cyc, dcyc + 3); end
        checks++; if (d_done !== 1) begin errors++; $display("FAIL ign_second_done got %0d exp 1", d_done); end
    endtask

    task automatic test_parity();
        pay_mem[0] = 8'($urandom);
        run(4'h1, 12'h001, -1);
        checks++; if (got[got_base + PRE_LEN + 17] !== 1'b0 || n_bad !== 0) begin errors++; $display("FAIL parity_len1 got %b bad %0d exp 0 0", got[got_base + PRE_LEN + 17], n_bad); end
        for (int i = 0; i < 3; i++) pay_mem[i] = 8'($urandom);
        run(4'h1, 12'h003, -1);
        checks++; if (got[got_base + PRE_LEN + 17] !== 1'b1 || n_bad !== 0) begin errors++; $display("FAIL parity_len3 got %b bad %0d exp 1 0", got[got_base + PRE_LEN + 17], n_bad); end
    endtask

    task automatic test_random();
        logic [3:0]  r;
        logic [11:0] len;
        int drop;
        for (int f = 0; f < 8; f++) begin
            pre_pat = 16'($urandom);
            r       = 4'($urandom);
            len     = 12'($urandom_range(0, 5));
            for (int i = 0; i < 6; i++) pay_mem[i] = 8'($urandom);
            drop = (len != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(len) - 1)) : -1;
            run(r, len, drop);
            checks++; if (n_got !== exp_q.size() || n_bad !== 0) begin errors++; $display("FAIL rand_frame_%0d got count %0d bad %0d exp %0d 0", f, n_got, n_bad, exp_q.size()); end
            checks++; if (d_done !== int'(drop < 0) || d_err !== int'(drop >= 0) || !gap_ok) begin errors++; $display("FAIL rand_flags_%0d got done %0d err %0d gap %0d exp %0d %0d 1", f, d_done, d_err, gap_ok, drop < 0, drop >= 0); end
        end
    endtask

    task automatic test_maxlen();
        pre_pat = 16'h5A3C;
        for (int i = 0; i < 4096; i++) pay_mem[i] = 8'($urandom);
        run(4'hF, 12'd4095, -1);
        checks++; if (n_got !== PRE_LEN + HDR_BITS + 8 * 4095 + TAIL_BITS) begin errors++; $display("FAIL maxlen_count got %0d exp %0d", n_got, PRE_LEN + HDR_BITS + 8 * 4095 + TAIL_BITS); end
        checks++; if (n_bad !== 0 || d_done !== 1) begin errors++; $display("FAIL maxlen_bits got bad %0d done %0d exp 0 1", n_bad, d_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_underrun();
        test_reset_mid();
        test_start_ignored();
        test_parity();
        test_random();
        test_maxlen();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
